// File: rtl/pb_timer_regs.sv
// pb_timer_regs: PicoBlaze-facing register bank for a single timer.
//
// The block occupies eight ports starting at BASE_ADDR. Address bits [7:3]
// select the block and bits [2:0] select the register:
//   0 CONTROL  r/w  [7] enable, [6] single-shot, [5] irq enable, [2:0] prescale
//   1 LIMIT_LO r/w  staging byte for the limit
//   2 LIMIT_HI r/w  a write commits {data, staged byte} to timer_limit
//   3 STATUS   r    timer_status
//   4 COUNT_LO r    live timer_count[7:0]; reading it snapshots the high byte
//   5 COUNT_HI r    snapshot taken by the last COUNT_LO read
//   6 IRQ      r/w1c {7'b0, irq_flag}
//   7 reserved, reads as zero
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   port_id, write_strobe, read_strobe, out_port, in_port
//                     PicoBlaze I/O bus; in_port is registered and is zero
//                     when the block is not addressed, so it can be OR-combined
//   interrupt, interrupt_ack
//                     level interrupt and its acknowledge
//   timer_control, timer_limit
//                     register outputs to the timer core
//   timer_status, timer_count, timer_disable, timer_int
//                     inputs from the timer core
module pb_timer_regs #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  port_id,
  input  logic        write_strobe,
  input  logic        read_strobe,
  input  logic [7:0]  out_port,
  output logic [7:0]  in_port,
  output logic        interrupt,
  input  logic        interrupt_ack,
  output logic [7:0]  timer_control,
  output logic [15:0] timer_limit,
  input  logic [7:0]  timer_status,
  input  logic [15:0] timer_count,
  input  logic        timer_disable,
  input  logic        timer_int
);

  logic       sel;
  logic [2:0] off;
  logic       wr;
  logic [7:0] lim_stage;
  logic [7:0] cnt_snap;
  logic       irq_flag;
  logic       int_d;
  logic       irq_set;
  logic       irq_clr;
  logic [7:0] rd_mux;

  assign sel = (port_id[7:3] == BASE_ADDR[7:3]);
  assign off = port_id[2:0];
  assign wr  = write_strobe & sel;

  assign irq_set = timer_int & ~int_d;
  assign irq_clr = interrupt_ack | (wr && (off == 3'd6) && out_port[0]);

  // Gated by reset so the CPU never sees a stale flag while reset is held.
  assign interrupt = irq_flag & timer_control[5] & ~rst_i;

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      3'd0: rd_mux = timer_control;
      3'd1: rd_mux = lim_stage;
      3'd2: rd_mux = timer_limit[15:8];
      3'd3: rd_mux = timer_status;
      3'd4: rd_mux = timer_count[7:0];
      3'd5: rd_mux = cnt_snap;
      3'd6: rd_mux = {7'b0, irq_flag};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_control <= 8'h00;
      timer_limit   <= 16'h0000;
      lim_stage     <= 8'h00;
      cnt_snap      <= 8'h00;
      irq_flag      <= 1'b0;
      int_d         <= 1'b0;
      in_port       <= 8'h00;
    end else begin
      if (wr && (off == 3'd0))
        timer_control <= out_port;
      // Later assignment overrides the write: disable always wins bit 7.
      if (timer_disable)
        timer_control[7] <= 1'b0;

      if (wr && (off == 3'd1))
        lim_stage <= out_port;
      if (wr && (off == 3'd2))
        timer_limit <= {out_port, lim_stage};

      // Freeze the high byte so a LO-then-HI read pair is coherent.
      if (read_strobe && sel && (off == 3'd4))
        cnt_snap <= timer_count[15:8];

      int_d <= timer_int;
      if (irq_set)
        irq_flag <= 1'b1;
      else if (irq_clr)
        irq_flag <= 1'b0;

      in_port <= sel ? rd_mux : 8'h00;
    end
  end

endmodule
